// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared types and header layout for the FTDI TX stream arbiter.
// Header word: magic in the top half, per-source sequence, source id in bit 0.
package ftdi_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;

  localparam int MAGIC_LSB = 16;
  localparam int SEQ_LSB   = 8;
  localparam int ID_LSB    = 0;

  function automatic logic [31:0] mk_hdr(
    input logic [15:0] magic,
    input logic [7:0]  seq,
    input logic        id
  );
    logic [31:0] h;
    h = '0;
    h[MAGIC_LSB +: 16] = magic;
    h[SEQ_LSB +: 8]    = seq;
    h[ID_LSB]          = id;
    return h;
  endfunction

endpackage

// File: rtl/ftdi_tx_rr_pick2.sv
// Two-request round-robin picker.
// On a tie the source that did not win last time is chosen.
module ftdi_tx_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (&req) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-locked round-robin arbiter for the FTDI TX stream.
// Optionally prefixes each packet with a source/sequence header word.
module ftdi_tx_arbiter
  import ftdi_tx_arbiter_pkg::*;
#(
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [31:0] s0_tdata,
  input  logic [3:0]  s0_tkeep,
  input  logic        s0_tlast,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [31:0] s1_tdata,
  input  logic [3:0]  s1_tkeep,
  input  logic        s1_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tlast,
  output logic        grant_id,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [7:0]  seq0;
  logic [7:0]  seq1;
  logic        gnt_valid;
  logic        gnt_id;
  logic        src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_keep;
  logic        src_last;
  logic [7:0]  cur_seq;
  logic        pkt_done;

  ftdi_tx_rr_pick2 u_pick (
    .req        ({s1_tvalid, s0_tvalid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign src_valid = grant_id ? s1_tvalid : s0_tvalid;
  assign src_data  = grant_id ? s1_tdata  : s0_tdata;
  assign src_keep  = grant_id ? s1_tkeep  : s0_tkeep;
  assign src_last  = grant_id ? s1_tlast  : s0_tlast;
  assign cur_seq   = grant_id ? seq1 : seq0;

  assign pkt_done = (state == DATA) && src_valid &&
                    m_tready && src_last;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (HDR_EN) state_nxt = HDR;
          else        state_nxt = DATA;
        end
      end
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = mk_hdr(HDR_MAGIC, cur_seq, grant_id);
        m_tkeep  = 4'hF;
        if (m_tready) state_nxt = DATA;
      end
      DATA: begin
        m_tvalid  = src_valid;
        m_tdata   = src_data;
        m_tkeep   = src_keep;
        m_tlast   = src_last;
        s0_tready = ~grant_id & m_tready;
        s1_tready = grant_id & m_tready;
        if (pkt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      seq0       <= '0;
      seq1       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_valid) grant_id <= gnt_id;
      if (pkt_done) begin
        last_grant <= grant_id;
        if (grant_id) seq1 <= seq1 + 8'd1;
        else          seq0 <= seq0 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Randomized bench for ftdi_tx_arbiter against a packet-level model.
// Models expected output as header words plus queued source beats.
module tb_ftdi_tx_arbiter;

  typedef struct packed {
    logic        gid;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  logic        clk;
  logic        rstn;
  logic        s0_tvalid, s0_tready, s0_tlast;
  logic [31:0] s0_tdata;
  logic [3:0]  s0_tkeep;
  logic        s1_tvalid, s1_tready, s1_tlast;
  logic [31:0] s1_tdata;
  logic [3:0]  s1_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        grant_id, busy;

  logic        b_s0_tready, b_s1_tready;
  logic        b_m_tvalid, b_m_tready, b_m_tlast;
  logic [31:0] b_m_tdata;
  logic [3:0]  b_m_tkeep;
  logic        b_grant_id, b_busy;

  ftdi_tx_arbiter #(.HDR_EN(1'b1), .HDR_MAGIC(16'hA55A)) dut (
    .clk(clk), .rstn(rstn),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .grant_id(grant_id), .busy(busy)
  );

  ftdi_tx_arbiter #(.HDR_EN(1'b0), .HDR_MAGIC(16'hA55A)) dut_nh (
    .clk(clk), .rstn(rstn),
    .s0_tvalid(s0_tvalid), .s0_tready(b_s0_tready),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(b_s1_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  beat_t q0[$], q1[$], sent0[$], sent1[$], exp_q[$], obs[$];
  int    mseq[2];
  bit    mlast;
  int    passed, total;
  bit    auto_drv;
  int    rdy_mode, rdy_cyc;
  bit    hs0, hs1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source drivers and sink ready, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    rdy_cyc++;
    if (auto_drv) begin
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      hs0 = 1'b0;
      hs1 = 1'b0;
      if (q0.size() > 0) begin
        s0_tvalid = 1'b1;
        s0_tdata  = q0[0].data;
        s0_tkeep  = q0[0].keep;
        s0_tlast  = q0[0].last;
      end else begin
        s0_tvalid = 1'b0;
      end
      if (q1.size() > 0) begin
        s1_tvalid = 1'b1;
        s1_tdata  = q1[0].data;
        s1_tkeep  = q1[0].keep;
        s1_tlast  = q1[0].last;
      end else begin
        s1_tvalid = 1'b0;
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
        default: m_tready = 1'($urandom % 2);
      endcase
    end
  end

  always @(negedge clk) begin
    beat_t b;
    hs0 = rstn && s0_tvalid && s0_tready;
    hs1 = rstn && s1_tvalid && s1_tready;
    if (rstn && m_tvalid && m_tready) begin
      b.gid  = grant_id;
      b.last = m_tlast;
      b.keep = m_tkeep;
      b.data = m_tdata;
      obs.push_back(b);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    q0.delete(); q1.delete();
    sent0.delete(); sent1.delete();
    exp_q.delete(); obs.delete();
    mseq[0] = 0; mseq[1] = 0;
    mlast = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    b_m_tready = 1'b0;
    hs0 = 1'b0; hs1 = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic stage(input int src, input int n,
                       input bit cnt_data, input bit rnd_keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.gid  = 1'(src);
      b.data = cnt_data ? 32'(i + 1) : $urandom;
      b.keep = rnd_keep ? 4'($urandom_range(1, 15)) : 4'hF;
      b.last = (i == n - 1);
      if (src == 0) begin q0.push_back(b); sent0.push_back(b); end
      else          begin q1.push_back(b); sent1.push_back(b); end
    end
  endtask

  task automatic expect_pkt(input int src);
    beat_t b;
    b.gid  = 1'(src);
    b.last = 1'b0;
    b.keep = 4'hF;
    b.data = 32'hA55A0000 | (32'(mseq[src]) << 8) | 32'(src);
    exp_q.push_back(b);
    do begin
      b = (src == 0) ? sent0.pop_front() : sent1.pop_front();
      exp_q.push_back(b);
    end while (!b.last);
    mseq[src] = (mseq[src] + 1) % 256;
    mlast = 1'(src);
  endtask

  // Packet order when every staged packet is already waiting
  task automatic expect_all();
    int src;
    while (sent0.size() > 0 || sent1.size() > 0) begin
      if (sent0.size() > 0 && sent1.size() > 0) src = mlast ? 0 : 1;
      else if (sent0.size() > 0)                src = 0;
      else                                      src = 1;
      expect_pkt(src);
    end
  endtask

  task automatic wait_obs(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (obs.size() >= n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready,
         s1_tready, busy, grant_id} !== '0)
      $display("FAIL reset_outs: got v=%b d=%h k=%h l=%b r=%b%b busy=%b g=%b want 0",
               m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready,
               s1_tready, busy, grant_id);
    else passed++;
    total++;
    if ({b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast, b_s0_tready,
         b_s1_tready, b_busy, b_grant_id} !== '0)
      $display("FAIL reset_outs_nohdr: got v=%b d=%h busy=%b want 0",
               b_m_tvalid, b_m_tdata, b_busy);
    else passed++;
    do_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, m_tvalid, grant_id} !== 3'b000)
      $display("FAIL idle_after_reset: got busy=%b v=%b g=%b want 000",
               busy, m_tvalid, grant_id);
    else passed++;
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    rdy_mode = 0;
    stage(0, 3, 1'b1, 1'b0);
    expect_all();
    wait_obs(exp_q.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to || obs.size() != exp_q.size())
      $display("FAIL single_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL single_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (obs.size() > 0 && obs[0].data !== 32'hA55A0000)
      $display("FAIL single_hdr: got %h want a55a0000", obs[0].data);
    else passed++;
  endtask

  task automatic test_both();
    bit to;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      stage(0, 2, 1'b0, 1'b0);
      stage(1, 2, 1'b0, 1'b0);
    end
    expect_all();
    wait_obs(exp_q.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to || obs.size() != exp_q.size())
      $display("FAIL both_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL both_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit          pv, pr;
    logic [31:0] pd;
    do_reset();
    rdy_mode = 1;
    stage(0, 4, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    #1;
    stage(1, 2, 1'b0, 1'b1);
    expect_pkt(0);
    expect_pkt(1);
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int c = 0; c < 300 && obs.size() < exp_q.size(); c++) begin
      @(negedge clk);
      #1;
      if (busy && grant_id == 1'b0) begin
        total++;
        if (s1_tready !== 1'b0)
          $display("FAIL bp_other_ready: got %b want 0", s1_tready);
        else passed++;
      end
      if (pv && !pr) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd)
          $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h",
                   m_tvalid, m_tdata, pd);
        else passed++;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata;
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs.size() != exp_q.size())
      $display("FAIL bp_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL bp_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      stage(0, $urandom_range(1, 5), 1'b0, 1'b1);
      stage(1, $urandom_range(1, 5), 1'b0, 1'b1);
    end
    expect_all();
    wait_obs(exp_q.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to || obs.size() != exp_q.size())
      $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL rand_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 257; i++) stage(0, 1, 1'b0, 1'b0);
    expect_all();
    wait_obs(exp_q.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to || obs.size() != exp_q.size())
      $display("FAIL wrap_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL wrap_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
    if (obs.size() >= 514) begin
      total++;
      if (obs[510].data !== 32'hA55AFF00)
        $display("FAIL wrap_ff: got %h want a55aff00", obs[510].data);
      else passed++;
      total++;
      if (obs[512].data !== 32'hA55A0000)
        $display("FAIL wrap_00: got %h want a55a0000", obs[512].data);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    rdy_mode = 0;
    stage(1, 4, 1'b0, 1'b0);
    wait_obs(2, to);
    @(posedge clk);
    #2;
    total++;
    if (to || m_tvalid !== 1'b1 || grant_id !== 1'b1)
      $display("FAIL mid_beat2: got to=%b v=%b g=%b want 0 1 1",
               to, m_tvalid, grant_id);
    else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s0_tready,
         s1_tready, busy, grant_id} !== '0)
      $display("FAIL mid_reset_outs: got v=%b d=%h busy=%b g=%b want 0",
               m_tvalid, m_tdata, busy, grant_id);
    else passed++;
    do_reset();
    stage(0, 2, 1'b0, 1'b0);
    expect_all();
    wait_obs(exp_q.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to || obs.size() != exp_q.size())
      $display("FAIL mid_count: got %0d want %0d", obs.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i])
        $display("FAIL mid_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (obs.size() > 0 && obs[0].data !== 32'hA55A0000)
      $display("FAIL mid_hdr: got %h want a55a0000", obs[0].data);
    else passed++;
  endtask

  task automatic test_nohdr();
    logic [31:0] d;
    auto_drv = 1'b0;
    do_reset();
    d = $urandom;
    @(posedge clk);
    #1;
    s1_tvalid = 1'b1;
    s1_tdata  = d;
    s1_tkeep  = 4'h3;
    s1_tlast  = 1'b1;
    b_m_tready = 1'b1;
    @(negedge clk);
    total++;
    if (b_m_tvalid !== 1'b0 || b_s1_tready !== 1'b0)
      $display("FAIL nohdr_bubble: got v=%b r=%b want 0 0",
               b_m_tvalid, b_s1_tready);
    else passed++;
    @(negedge clk);
    total++;
    if ({b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast} !== {1'b1, d, 4'h3, 1'b1})
      $display("FAIL nohdr_beat: got v=%b d=%h k=%h l=%b want 1 %h 3 1",
               b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast, d);
    else passed++;
    total++;
    if ({b_s1_tready, b_s0_tready, b_grant_id} !== 3'b101)
      $display("FAIL nohdr_grant: got r1=%b r0=%b g=%b want 1 0 1",
               b_s1_tready, b_s0_tready, b_grant_id);
    else passed++;
    @(posedge clk);
    #1;
    s1_tvalid = 1'b0;
    @(negedge clk);
    total++;
    if (b_busy !== 1'b0 || b_m_tvalid !== 1'b0)
      $display("FAIL nohdr_idle: got busy=%b v=%b want 0 0", b_busy, b_m_tvalid);
    else passed++;
    auto_drv = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0;
    rstn = 1'b0;
    auto_drv = 1'b1;
    rdy_mode = 0; rdy_cyc = 0;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
    m_tready = 1'b1; b_m_tready = 1'b0;
    hs0 = 1'b0; hs1 = 1'b0;
    mseq[0] = 0; mseq[1] = 0; mlast = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_mid();
    test_nohdr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
